// File: rtl/prefetch_mem_arbiter_pkg.sv
// Shared types and constants for the prefetch/demand memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_src_t : which requester wins the IDLE decision
//   LINE_OFFSET : lowest address bit that identifies a cacheline
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT_D  = 3'd1,
        GRANT_I  = 3'd2,
        GRANT_PF = 3'd3,
        DONE     = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_D  = 2'd0,
        SRC_I  = 2'd1,
        SRC_PF = 2'd2
    } grant_src_t;

    localparam int LINE_OFFSET = 5;

endpackage

// File: rtl/prefetch_mem_arbiter_pf_req_latch.sv
// One-entry prefetch request latch.
// A capture overwrites whatever is pending (older request is silently dropped).
// A clear empties the entry; a capture in the same cycle wins over the clear.
// Ports:
//   clk, rst       clock, async active-low reset
//   capture        load addr_in and mark valid
//   clear          drop the pending request
//   addr_in        request address
//   pend_valid     a request is waiting
//   pend_addr      address of the waiting request
module pf_req_latch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clear) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            valid_d = 1'b1;
            addr_d  = addr_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign pend_valid = valid_q;
    assign pend_addr  = addr_q;

endmodule

// File: rtl/prefetch_mem_arbiter.sv
// Arbitrates D-cache, I-cache and next-line prefetch requests onto one memory port.
// Demand (D over I) always wins; a prefetch waits in a one-entry latch until the
// arbiter is idle with no demand. All outputs are registered.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no transaction, pick D > I > pending prefetch
//   GRANT_D  | D-cache read or writeback in flight on mem_*
//   GRANT_I  | I-cache read in flight
//   GRANT_PF | prefetch read in flight
//   DONE     | one idle cycle so the requester can drop its level
//
// Ports:
//   clk, rst                          clock, async active-low reset
//   pf_read/pf_address                prefetch pulse + line address
//   pf_rdata/pf_resp                  prefetched line + completion pulse
//   i_read/i_address/i_rdata/i_resp   I-cache demand port
//   d_read/d_write/d_address/d_wdata  D-cache demand port (request side)
//   d_rdata/d_resp                    D-cache demand port (response side)
//   mem_read/mem_write/mem_address/mem_wdata   memory request (registered)
//   mem_rdata/mem_resp                memory response
module prefetch_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int PF_ENABLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pf_read,
    input  logic [ADDR_W-1:0] pf_address,
    output logic [LINE_W-1:0] pf_rdata,
    output logic              pf_resp,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] pf_rdata_q, pf_rdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              pf_resp_q, pf_resp_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              pf_capture;
    logic              pf_clear;
    logic              pf_pend_valid;
    logic [ADDR_W-1:0] pf_pend_addr;
    logic              grant_go;
    grant_src_t        grant_src;

    // Pulses arriving while a prefetch is already in flight are ignored.
    assign pf_capture = (PF_ENABLE != 0) && pf_read && (state_q != GRANT_PF);

    pf_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_pf_req_latch (
        .clk        (clk),
        .rst        (rst),
        .capture    (pf_capture),
        .clear      (pf_clear),
        .addr_in    (pf_address),
        .pend_valid (pf_pend_valid),
        .pend_addr  (pf_pend_addr)
    );

    always_comb begin
        grant_go  = 1'b0;
        grant_src = SRC_D;
        if (d_read || d_write) begin
            grant_go  = 1'b1;
            grant_src = SRC_D;
        end else if (i_read) begin
            grant_go  = 1'b1;
            grant_src = SRC_I;
        end else if (pf_pend_valid) begin
            grant_go  = 1'b1;
            grant_src = SRC_PF;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        pf_rdata_d    = pf_rdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        pf_resp_d     = 1'b0;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;
        pf_clear      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    case (grant_src)
                        SRC_D: begin
                            state_d       = GRANT_D;
                            // read+write together is treated as a writeback
                            mem_write_d   = d_write;
                            mem_read_d    = !d_write;
                            mem_address_d = d_address;
                            mem_wdata_d   = d_wdata;
                            // demand fetch of the pending prefetch line makes it redundant
                            if (d_address[ADDR_W-1:LINE_OFFSET] ==
                                pf_pend_addr[ADDR_W-1:LINE_OFFSET]) begin
                                pf_clear = 1'b1;
                            end
                        end
                        SRC_I: begin
                            state_d       = GRANT_I;
                            mem_read_d    = 1'b1;
                            mem_write_d   = 1'b0;
                            mem_address_d = i_address;
                            mem_wdata_d   = '0;
                            if (i_address[ADDR_W-1:LINE_OFFSET] ==
                                pf_pend_addr[ADDR_W-1:LINE_OFFSET]) begin
                                pf_clear = 1'b1;
                            end
                        end
                        default: begin
                            state_d       = GRANT_PF;
                            mem_read_d    = 1'b1;
                            mem_write_d   = 1'b0;
                            mem_address_d = pf_pend_addr;
                            mem_wdata_d   = '0;
                            pf_clear      = 1'b1;
                        end
                    endcase
                end
            end
            GRANT_D: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_resp_d = 1'b1;
                    state_d  = DONE;
                end
            end
            GRANT_I: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_resp_d    = 1'b1;
                    state_d     = DONE;
                end
            end
            GRANT_PF: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    pf_rdata_d  = mem_rdata;
                    pf_resp_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            pf_rdata_q    <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            pf_resp_q     <= 1'b0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            pf_rdata_q    <= pf_rdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            pf_resp_q     <= pf_resp_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign pf_rdata    = pf_rdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign pf_resp     = pf_resp_q;
    assign i_resp      = i_resp_q;
    assign d_resp      = d_resp_q;

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
module tb_prefetch_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         pf_read = 1'b0;
    logic [31:0]  pf_address = '0;
    logic [255:0] pf_rdata;
    logic         pf_resp;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    // second instance with prefetching disabled
    logic         x_pf_read = 1'b0;
    logic [31:0]  x_pf_address = '0;
    logic [255:0] x_pf_rdata;
    logic         x_pf_resp;
    logic [255:0] x_i_rdata;
    logic         x_i_resp;
    logic [255:0] x_d_rdata;
    logic         x_d_resp;
    logic         x_mem_read;
    logic         x_mem_write;
    logic [31:0]  x_mem_address;
    logic [255:0] x_mem_wdata;
    logic         x_mem_resp = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prefetch_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .PF_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    prefetch_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .PF_ENABLE(0)) dut_nopf (
        .clk(clk), .rst(rst),
        .pf_read(x_pf_read), .pf_address(x_pf_address), .pf_rdata(x_pf_rdata), .pf_resp(x_pf_resp),
        .i_read(1'b0), .i_address(32'h0), .i_rdata(x_i_rdata), .i_resp(x_i_resp),
        .d_read(1'b0), .d_write(1'b0), .d_address(32'h0), .d_wdata(256'h0),
        .d_rdata(x_d_rdata), .d_resp(x_d_resp),
        .mem_read(x_mem_read), .mem_write(x_mem_write), .mem_address(x_mem_address),
        .mem_wdata(x_mem_wdata), .mem_rdata(256'h0), .mem_resp(x_mem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // bounded wait for the arbiter to issue a memory request
    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (!(mem_read || mem_write) && i < 20) begin
            tick();
            i++;
        end
        check({tag, " request issued"}, 256'(mem_read || mem_write), 256'd1);
    endtask

    task automatic mem_reply(input logic [255:0] data);
        mem_rdata = data;
        mem_resp  = 1'b1;
        tick();
        mem_resp  = 1'b0;
    endtask

    initial begin
        logic [255:0] dat_a, dat_b, dat_c, dat_d, dat_e, dat_f, dat_g, dat_h, dat_j, dat_k;
        int extra;
        dat_a = {32{8'hA5}};
        dat_b = {32{8'hB1}};
        dat_c = {32{8'hC2}};
        dat_d = {32{8'hD3}};
        dat_e = {32{8'hE4}};
        dat_f = {32{8'hF5}};
        dat_g = {32{8'h16}};
        dat_h = {32{8'h27}};
        dat_j = {32{8'h38}};
        dat_k = {32{8'h49}};

        // reset state
        tick();
        tick();
        check("reset mem_read", 256'(mem_read), 256'd0);
        check("reset mem_address", 256'(mem_address), 256'd0);
        check("reset pf_resp", 256'(pf_resp), 256'd0);
        rst = 1'b1;
        tick();

        // 1: lone prefetch
        pf_read = 1'b1; pf_address = 32'h0000_1020;
        tick();
        pf_read = 1'b0;
        wait_req("t1");
        check("t1 mem_read", 256'(mem_read), 256'd1);
        check("t1 mem_address", 256'(mem_address), 256'h1020);
        mem_reply(dat_a);
        check("t1 pf_resp", 256'(pf_resp), 256'd1);
        check("t1 pf_rdata", pf_rdata, dat_a);
        check("t1 mem_read cleared", 256'(mem_read), 256'd0);
        tick();
        check("t1 pf_resp one cycle", 256'(pf_resp), 256'd0);
        tick();

        // 2: demand beats prefetch
        pf_read = 1'b1; pf_address = 32'h2040;
        i_read = 1'b1; i_address = 32'h3000;
        tick();
        pf_read = 1'b0;
        check("t2 i first address", 256'(mem_address), 256'h3000);
        mem_reply(dat_b);
        check("t2 i_resp", 256'(i_resp), 256'd1);
        check("t2 i_rdata", i_rdata, dat_b);
        check("t2 no pf_resp yet", 256'(pf_resp), 256'd0);
        i_read = 1'b0;
        wait_req("t2 pf");
        check("t2 pf address", 256'(mem_address), 256'h2040);
        mem_reply(dat_c);
        check("t2 pf_resp", 256'(pf_resp), 256'd1);
        check("t2 pf_rdata", pf_rdata, dat_c);
        tick();
        tick();

        // 3: overwrite while D writeback is in flight
        d_write = 1'b1; d_address = 32'h400; d_wdata = dat_d;
        pf_read = 1'b1; pf_address = 32'h100;
        tick();
        check("t3 mem_write", 256'(mem_write), 256'd1);
        check("t3 mem_read", 256'(mem_read), 256'd0);
        check("t3 wb address", 256'(mem_address), 256'h400);
        check("t3 wb data", mem_wdata, dat_d);
        pf_address = 32'h120;
        tick();
        pf_read = 1'b0;
        tick();
        mem_reply(dat_e);
        check("t3 d_resp", 256'(d_resp), 256'd1);
        check("t3 d_rdata unchanged on write", d_rdata, 256'd0);
        d_write = 1'b0;
        wait_req("t3 pf");
        check("t3 pf address newest", 256'(mem_address), 256'h120);
        mem_reply(dat_f);
        check("t3 pf_resp", 256'(pf_resp), 256'd1);
        check("t3 pf_rdata", pf_rdata, dat_f);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_read || pf_resp) extra++;
        end
        check("t3 no stale prefetch", 256'(extra), 256'd0);

        // 4: redundant prefetch dropped by demand to same line
        pf_read = 1'b1; pf_address = 32'h5020;
        tick();
        pf_read = 1'b0;
        i_read = 1'b1; i_address = 32'h5024;
        tick();
        check("t4 i address", 256'(mem_address), 256'h5024);
        mem_reply(dat_g);
        check("t4 i_resp", 256'(i_resp), 256'd1);
        check("t4 i_rdata", i_rdata, dat_g);
        i_read = 1'b0;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_read || pf_resp) extra++;
        end
        check("t4 prefetch dropped", 256'(extra), 256'd0);

        // 4b: capture in the drop cycle wins
        pf_read = 1'b1; pf_address = 32'h6000;
        tick();
        pf_address = 32'h7000;
        i_read = 1'b1; i_address = 32'h6000;
        tick();
        pf_read = 1'b0;
        check("t4b i address", 256'(mem_address), 256'h6000);
        mem_reply(dat_h);
        i_read = 1'b0;
        wait_req("t4b pf");
        check("t4b captured pf address", 256'(mem_address), 256'h7000);
        mem_reply(dat_j);
        check("t4b pf_resp", 256'(pf_resp), 256'd1);
        tick();
        tick();

        // 5: reset mid-operation
        d_read = 1'b1; d_address = 32'h800;
        tick();
        check("t5 d read issued", 256'(mem_read), 256'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5 async mem_read", 256'(mem_read), 256'd0);
        check("t5 async mem_address", 256'(mem_address), 256'd0);
        check("t5 async pf_rdata", pf_rdata, 256'd0);
        check("t5 async i_rdata", i_rdata, 256'd0);
        d_read = 1'b0;
        tick();
        rst = 1'b1;
        mem_rdata = dat_k;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check("t5 late mem_resp d_resp", 256'(d_resp), 256'd0);
        check("t5 late mem_resp d_rdata", d_rdata, 256'd0);
        check("t5 idle mem_read", 256'(mem_read), 256'd0);

        // 6: prefetch disabled
        extra = 0;
        x_pf_read = 1'b1; x_pf_address = 32'h1020;
        tick();
        x_pf_read = 1'b0;
        tick();
        x_pf_read = 1'b1; x_pf_address = 32'h1040;
        tick();
        x_pf_read = 1'b0;
        for (int k = 0; k < 6; k++) begin
            x_mem_resp = (k == 2);
            tick();
            if (x_mem_read || x_pf_resp) extra++;
        end
        x_mem_resp = 1'b0;
        check("t6 pf disabled activity", 256'(extra), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
